// File: rtl/raw_link_fifo_rd_framer.sv
`default_nettype none
// ============================================================================
// Module   : raw_link_fifo_rd_framer
// Brief    : Pops the 512x44 link FIFO, absorbs RAM read latency in a skid
//            buffer, streams valid/ready words and checks SOP/EOP/tag framing.
// Revision : 1.0 - initial release
// ============================================================================
module raw_link_fifo_rd_framer #(
    parameter int RD_LATENCY = 1,
    parameter int SKID_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic             rd_clk,
    input  logic             rd_rst_n,
    output logic             fifo_rd_en,
    input  logic             fifo_rd_empty,
    input  logic [43:0]      fifo_rd_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [31:0]      m_data,
    output logic [3:0]       m_keep,
    output logic             m_sop,
    output logic             m_eop,
    output logic [5:0]       m_tag,
    output logic             err_orphan,
    output logic             err_sop_dup,
    output logic             err_tag,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int c_PTR_W = $clog2(SKID_DEPTH);
    localparam int c_OCC_W = c_PTR_W + 2;
    localparam logic [c_OCC_W-1:0] c_DEPTH = c_OCC_W'(SKID_DEPTH);

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        IN_FRAME = 1'b1
    } state_t;

    logic                  r_run;
    logic [RD_LATENCY-1:0] r_pipe;
    logic [43:0]           r_mem [SKID_DEPTH];
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_PTR_W:0]      r_skid_cnt;
    logic [c_OCC_W-1:0]    w_inflight;
    logic [c_OCC_W-1:0]    w_occ;
    logic                  w_push;
    logic                  w_hs;
    logic [43:0]           w_head;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  w_orphan;
    logic                  w_dup;
    logic                  w_done;
    logic                  w_tag_err;
    logic [5:0]            w_tag_exp;
    logic [5:0]            r_last_tag;
    logic                  r_tag_seen;
    logic [1:0]            w_err_add;
    logic [CNT_W:0]        w_err_sum;
    logic                  r_err_orphan;
    logic                  r_err_sop_dup;
    logic                  r_err_tag;
    logic [CNT_W-1:0]      r_frame_cnt;
    logic [CNT_W-1:0]      r_err_cnt;

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            w_inflight = w_inflight + c_OCC_W'(r_pipe[i]);
        end
    end

    // Reads already in flight reserve their skid slot, so the buffer cannot overflow.
    assign w_occ      = c_OCC_W'(r_skid_cnt) + w_inflight;
    assign fifo_rd_en = r_run && !fifo_rd_empty && (w_occ < c_DEPTH);
    assign w_push     = r_pipe[RD_LATENCY-1];
    assign m_valid    = (r_skid_cnt != '0);
    assign w_hs       = m_valid && m_ready;
    assign w_head     = m_valid ? r_mem[r_rd_ptr] : 44'd0;
    assign m_data     = w_head[31:0];
    assign m_keep     = w_head[35:32];
    assign m_sop      = w_head[36];
    assign m_eop      = w_head[37];
    assign m_tag      = w_head[43:38];

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            r_run      <= 1'b0;
            r_pipe     <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_skid_cnt <= '0;
        end else begin
            r_run  <= 1'b1;
            r_pipe <= (r_pipe << 1) | RD_LATENCY'(fifo_rd_en);
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_hs)   r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            case ({w_push, w_hs})
                2'b10:   r_skid_cnt <= r_skid_cnt + (c_PTR_W + 1)'(1);
                2'b01:   r_skid_cnt <= r_skid_cnt - (c_PTR_W + 1)'(1);
                default: r_skid_cnt <= r_skid_cnt;
            endcase
        end
    end

    always_ff @(posedge rd_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= fifo_rd_data;
    end

    assign w_tag_exp = r_last_tag + 6'd1;
    assign w_tag_err = w_hs && m_sop && r_tag_seen && (m_tag != w_tag_exp);

    always_comb begin
        w_state_nxt = r_state;
        w_orphan    = 1'b0;
        w_dup       = 1'b0;
        w_done      = 1'b0;
        if (w_hs) begin
            case (r_state)
                IDLE: begin
                    if (m_sop) begin
                        if (m_eop) w_done = 1'b1;
                        else       w_state_nxt = IN_FRAME;
                    end else begin
                        w_orphan = 1'b1;
                    end
                end
                IN_FRAME: begin
                    // A duplicate SOP restarts the frame; it still closes if EOP rides along.
                    if (m_sop) w_dup = 1'b1;
                    if (m_eop) begin
                        w_done      = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    assign w_err_add = {1'b0, w_orphan} + {1'b0, w_dup} + {1'b0, w_tag_err};
    assign w_err_sum = {1'b0, r_err_cnt} + (CNT_W + 1)'(w_err_add);

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            r_state       <= IDLE;
            r_last_tag    <= '0;
            r_tag_seen    <= 1'b0;
            r_err_orphan  <= 1'b0;
            r_err_sop_dup <= 1'b0;
            r_err_tag     <= 1'b0;
            r_frame_cnt   <= '0;
            r_err_cnt     <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_err_orphan  <= w_orphan;
            r_err_sop_dup <= w_dup;
            r_err_tag     <= w_tag_err;
            if (w_hs && m_sop) begin
                r_last_tag <= m_tag;
                r_tag_seen <= 1'b1;
            end
            if (w_done && (r_frame_cnt != '1)) r_frame_cnt <= r_frame_cnt + CNT_W'(1);
            r_err_cnt <= w_err_sum[CNT_W] ? '1 : w_err_sum[CNT_W-1:0];
        end
    end

    assign err_orphan  = r_err_orphan;
    assign err_sop_dup = r_err_sop_dup;
    assign err_tag     = r_err_tag;
    assign frame_cnt   = r_frame_cnt;
    assign err_cnt     = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_raw_link_fifo_rd_framer.sv
`default_nettype none
// ============================================================================
// Module   : tb_raw_link_fifo_rd_framer
// Brief    : Directed bench with FIFO models for latency 1 and latency 2 DUTs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_raw_link_fifo_rd_framer;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic        rd_en1, empty1, v1, r1, s1, e1, eo1, ed1, et1;
    logic [43:0] rdata1;
    logic [31:0] d1;
    logic [3:0]  k1;
    logic [5:0]  t1;
    logic [15:0] fc1, ec1;

    logic        rd_en2, empty2, v2, r2, s2, e2, eo2, ed2, et2;
    logic [43:0] rdata2, stage2;
    logic [31:0] d2;
    logic [3:0]  k2;
    logic [5:0]  t2;
    logic [15:0] fc2, ec2;

    raw_link_fifo_rd_framer #(.RD_LATENCY(1), .SKID_DEPTH(4), .CNT_W(16)) u_dut1 (
        .rd_clk(clk), .rd_rst_n(rst_n), .fifo_rd_en(rd_en1), .fifo_rd_empty(empty1),
        .fifo_rd_data(rdata1), .m_valid(v1), .m_ready(r1), .m_data(d1), .m_keep(k1),
        .m_sop(s1), .m_eop(e1), .m_tag(t1), .err_orphan(eo1), .err_sop_dup(ed1),
        .err_tag(et1), .frame_cnt(fc1), .err_cnt(ec1)
    );

    raw_link_fifo_rd_framer #(.RD_LATENCY(2), .SKID_DEPTH(4), .CNT_W(16)) u_dut2 (
        .rd_clk(clk), .rd_rst_n(rst_n), .fifo_rd_en(rd_en2), .fifo_rd_empty(empty2),
        .fifo_rd_data(rdata2), .m_valid(v2), .m_ready(r2), .m_data(d2), .m_keep(k2),
        .m_sop(s2), .m_eop(e2), .m_tag(t2), .err_orphan(eo2), .err_sop_dup(ed2),
        .err_tag(et2), .frame_cnt(fc2), .err_cnt(ec2)
    );

    // FIFO models: writes from the stimulus side, reads from the model side
    logic [43:0] mem1 [0:4095];
    logic [43:0] mem2 [0:4095];
    int wp1 = 0, rp1 = 0, viol1 = 0;
    int wp2 = 0, rp2 = 0, viol2 = 0;
    assign empty1 = (wp1 == rp1);
    assign empty2 = (wp2 == rp2);

    always @(posedge clk) begin
        if (!rst_n) rp1 <= wp1;
        else if (rd_en1) begin
            if (rp1 == wp1) viol1 <= viol1 + 1;
            else begin
                rdata1 <= mem1[rp1];
                rp1    <= rp1 + 1;
            end
        end
    end

    always @(posedge clk) begin
        rdata2 <= stage2;
        if (!rst_n) rp2 <= wp2;
        else if (rd_en2) begin
            if (rp2 == wp2) viol2 <= viol2 + 1;
            else begin
                stage2 <= mem2[rp2];
                rp2    <= rp2 + 1;
            end
        end
    end

    // Output capture and error-pulse bookkeeping (pulse index = word that caused it)
    logic [43:0] out1 [0:4095];
    logic [43:0] out2 [0:4095];
    int oc1 = 0, oc2 = 0, pc1 = 0;
    int no1 = 0, nd1 = 0, nt1 = 0, io1 = -1, id1 = -1, it1 = -1;

    always @(posedge clk) begin
        if (v1 && r1) begin
            out1[oc1] <= {t1, e1, s1, k1, d1};
            oc1       <= oc1 + 1;
        end
        if (v2 && r2) begin
            out2[oc2] <= {t2, e2, s2, k2, d2};
            oc2       <= oc2 + 1;
        end
        if (rd_en1) pc1 <= pc1 + 1;
        if (eo1) begin no1 <= no1 + 1; io1 <= oc1 - 1; end
        if (ed1) begin nd1 <= nd1 + 1; id1 <= oc1 - 1; end
        if (et1) begin nt1 <= nt1 + 1; it1 <= oc1 - 1; end
    end

    function automatic logic [43:0] mkw(input logic [5:0] tag, input logic sop, input logic eop,
                                        input logic [3:0] keep, input logic [31:0] d);
        return {tag, eop, sop, keep, d};
    endfunction

    task automatic push1(input logic [43:0] w);
        mem1[wp1] = w;
        wp1 = wp1 + 1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        r1 = 1'b0;
        r2 = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        push1(mkw(6'd7, 1'b1, 1'b1, 4'hF, 32'hDEAD_BEEF));
        #1;
        n_vec++; if (rd_en1 !== 1'b0) begin n_err++; $display("FAIL reset_rd_en1 got %b exp 0", rd_en1); end
        n_vec++; if (rd_en2 !== 1'b0) begin n_err++; $display("FAIL reset_rd_en2 got %b exp 0", rd_en2); end
        n_vec++; if (v1 !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b exp 0", v1); end
        n_vec++; if (d1 !== 32'd0) begin n_err++; $display("FAIL reset_data got %h exp 0", d1); end
        n_vec++; if (fc1 !== 16'd0) begin n_err++; $display("FAIL reset_frame_cnt got %0d exp 0", fc1); end
        n_vec++; if (ec1 !== 16'd0) begin n_err++; $display("FAIL reset_err_cnt got %0d exp 0", ec1); end
        n_vec++; if ({eo1, ed1, et1} !== 3'b000) begin n_err++; $display("FAIL reset_pulses got %b exp 000", {eo1, ed1, et1}); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++; if (v1 !== 1'b0) begin n_err++; $display("FAIL reset_flushed_valid got %b exp 0", v1); end
    endtask

    task automatic test_basic();
        int wb, base, fp, fv, nv, lv;
        base = oc1;
        wb   = wp1;
        r1   = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) push1(mkw(6'd0, i == 0, i == 7, 4'hF, 32'hA000_0000 + 32'(i)));
        #1;
        fp = -1; fv = -1; nv = 0; lv = -1;
        for (int k = 0; k < 30; k++) begin
            if (fp < 0 && rd_en1) fp = k;
            if (v1) begin
                if (fv < 0) fv = k;
                nv++;
                lv = k;
            end
            @(negedge clk);
            #1;
        end
        n_vec++; if (fp !== 0) begin n_err++; $display("FAIL basic_first_pop got %0d exp 0", fp); end
        n_vec++; if (fv - fp !== 2) begin n_err++; $display("FAIL basic_latency got %0d exp 2", fv - fp); end
        n_vec++; if (nv !== 8) begin n_err++; $display("FAIL basic_beats got %0d exp 8", nv); end
        n_vec++; if (lv - fv !== 7) begin n_err++; $display("FAIL basic_back_to_back span got %0d exp 7", lv - fv); end
        n_vec++; if (oc1 - base !== 8) begin n_err++; $display("FAIL basic_count got %0d exp 8", oc1 - base); end
        for (int i = 0; i < 8; i++) begin
            n_vec++;
            if (out1[base+i] !== mem1[wb+i]) begin
                n_err++; $display("FAIL basic_word%0d got %h exp %h", i, out1[base+i], mem1[wb+i]);
            end
        end
        n_vec++; if (fc1 !== 16'd1) begin n_err++; $display("FAIL basic_frame_cnt got %0d exp 1", fc1); end
        n_vec++; if (ec1 !== 16'd0) begin n_err++; $display("FAIL basic_err_cnt got %0d exp 0", ec1); end
        n_vec++; if (no1 + nd1 + nt1 !== 0) begin n_err++; $display("FAIL basic_pulses got %0d exp 0", no1 + nd1 + nt1); end
    endtask

    task automatic test_stall();
        int wb, base, pb;
        r1 = 1'b0;
        @(negedge clk);
        wb = wp1; base = oc1; pb = pc1;
        for (int i = 0; i < 20; i++)
            push1(mkw(6'd1, i == 0, i == 19, 4'(i), $urandom));
        repeat (30) @(negedge clk);
        n_vec++; if (pc1 - pb !== 4) begin n_err++; $display("FAIL stall_pops got %0d exp 4", pc1 - pb); end
        n_vec++; if (v1 !== 1'b1) begin n_err++; $display("FAIL stall_valid got %b exp 1", v1); end
        n_vec++; if (oc1 !== base) begin n_err++; $display("FAIL stall_no_output got %0d exp %0d", oc1, base); end
        r1 = 1'b1;
        for (int k = 0; k < 100 && oc1 < base + 20; k++) @(negedge clk);
        n_vec++; if (oc1 !== base + 20) begin n_err++; $display("FAIL stall_drain got %0d exp %0d", oc1 - base, 20); end
        for (int i = 0; i < 20; i++) begin
            n_vec++;
            if (out1[base+i] !== mem1[wb+i]) begin
                n_err++; $display("FAIL stall_word%0d got %h exp %h", i, out1[base+i], mem1[wb+i]);
            end
        end
        repeat (2) @(negedge clk);
        n_vec++; if (fc1 !== 16'd2) begin n_err++; $display("FAIL stall_frame_cnt got %0d exp 2", fc1); end
        n_vec++; if (ec1 !== 16'd0) begin n_err++; $display("FAIL stall_err_cnt got %0d exp 0", ec1); end
    endtask

    task automatic test_tags();
        logic [5:0] tg [4] = '{6'd62, 6'd63, 6'd0, 6'd2};
        int base, nt0, no0, nd0;
        apply_reset();
        r1 = 1'b1;
        base = oc1; nt0 = nt1; no0 = no1; nd0 = nd1;
        for (int i = 0; i < 4; i++) push1(mkw(tg[i], 1'b1, 1'b1, 4'h3, 32'hC0 + 32'(i)));
        for (int k = 0; k < 50 && oc1 < base + 4; k++) @(negedge clk);
        repeat (3) @(negedge clk);
        n_vec++; if (oc1 !== base + 4) begin n_err++; $display("FAIL tags_drain got %0d exp 4", oc1 - base); end
        n_vec++; if (nt1 - nt0 !== 1) begin n_err++; $display("FAIL tags_pulses got %0d exp 1", nt1 - nt0); end
        n_vec++; if (it1 !== base + 3) begin n_err++; $display("FAIL tags_which_word got %0d exp %0d", it1 - base, 3); end
        n_vec++; if (fc1 !== 16'd4) begin n_err++; $display("FAIL tags_frame_cnt got %0d exp 4", fc1); end
        n_vec++; if (ec1 !== 16'd1) begin n_err++; $display("FAIL tags_err_cnt got %0d exp 1", ec1); end
        n_vec++; if ((no1 - no0) + (nd1 - nd0) !== 0) begin n_err++; $display("FAIL tags_other_pulses got %0d exp 0", (no1 - no0) + (nd1 - nd0)); end
    endtask

    task automatic test_framing();
        int base, no0, nd0, nt0;
        apply_reset();
        r1 = 1'b1;
        base = oc1; no0 = no1; nd0 = nd1; nt0 = nt1;
        push1(mkw(6'd0, 1'b0, 1'b0, 4'hF, 32'h1111_0000));
        push1(mkw(6'd5, 1'b1, 1'b0, 4'hF, 32'h1111_0001));
        push1(mkw(6'd6, 1'b1, 1'b1, 4'h1, 32'h1111_0002));
        for (int k = 0; k < 50 && oc1 < base + 3; k++) @(negedge clk);
        repeat (3) @(negedge clk);
        n_vec++; if (no1 - no0 !== 1) begin n_err++; $display("FAIL framing_orphan_cnt got %0d exp 1", no1 - no0); end
        n_vec++; if (io1 !== base) begin n_err++; $display("FAIL framing_orphan_word got %0d exp 0", io1 - base); end
        n_vec++; if (nd1 - nd0 !== 1) begin n_err++; $display("FAIL framing_dup_cnt got %0d exp 1", nd1 - nd0); end
        n_vec++; if (id1 !== base + 2) begin n_err++; $display("FAIL framing_dup_word got %0d exp 2", id1 - base); end
        n_vec++; if (nt1 !== nt0) begin n_err++; $display("FAIL framing_tag_pulses got %0d exp 0", nt1 - nt0); end
        n_vec++; if (fc1 !== 16'd1) begin n_err++; $display("FAIL framing_frame_cnt got %0d exp 1", fc1); end
        n_vec++; if (ec1 !== 16'd2) begin n_err++; $display("FAIL framing_err_cnt got %0d exp 2", ec1); end
    endtask

    task automatic test_reset_mid();
        int ob, wb;
        r1 = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 10; i++) push1(mkw(6'd20, i == 0, i == 9, 4'hF, 32'hBAD0_0000 + 32'(i)));
        repeat (3) @(negedge clk);
        n_vec++; if (v1 !== 1'b1) begin n_err++; $display("FAIL midrst_pre_valid got %b exp 1", v1); end
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (v1 !== 1'b0) begin n_err++; $display("FAIL midrst_valid got %b exp 0", v1); end
        n_vec++; if (rd_en1 !== 1'b0) begin n_err++; $display("FAIL midrst_rd_en got %b exp 0", rd_en1); end
        n_vec++; if (fc1 !== 16'd0) begin n_err++; $display("FAIL midrst_frame_cnt got %0d exp 0", fc1); end
        n_vec++; if (ec1 !== 16'd0) begin n_err++; $display("FAIL midrst_err_cnt got %0d exp 0", ec1); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        ob = oc1;
        r1 = 1'b1;
        repeat (20) @(negedge clk);
        n_vec++; if (oc1 !== ob) begin n_err++; $display("FAIL midrst_stale_words got %0d exp 0", oc1 - ob); end
        wb = wp1;
        push1(mkw(6'd9, 1'b1, 1'b0, 4'hF, 32'h5555_0000));
        push1(mkw(6'd9, 1'b0, 1'b1, 4'h7, 32'h5555_0001));
        for (int k = 0; k < 50 && oc1 < ob + 2; k++) @(negedge clk);
        repeat (3) @(negedge clk);
        n_vec++; if (oc1 !== ob + 2) begin n_err++; $display("FAIL midrst_new_count got %0d exp 2", oc1 - ob); end
        for (int i = 0; i < 2; i++) begin
            n_vec++;
            if (out1[ob+i] !== mem1[wb+i]) begin
                n_err++; $display("FAIL midrst_word%0d got %h exp %h", i, out1[ob+i], mem1[wb+i]);
            end
        end
        n_vec++; if (fc1 !== 16'd1) begin n_err++; $display("FAIL midrst_new_frame_cnt got %0d exp 1", fc1); end
        n_vec++; if (ec1 !== 16'd0) begin n_err++; $display("FAIL midrst_new_err_cnt got %0d exp 0", ec1); end
    endtask

    task automatic test_random();
        logic [5:0] tag;
        int rem, nfr;
        logic sop, eop;
        tag = 6'd40; rem = 0; nfr = 0;
        for (int i = 0; i < 1000; i++) begin
            sop = (rem == 0);
            if (sop) rem = $urandom_range(1, 4);
            if (i == 999) rem = 1;
            eop = (rem == 1);
            rem--;
            mem2[i] = mkw(tag, sop, eop, 4'($urandom), $urandom);
            if (eop) begin
                nfr++;
                tag = tag + 6'd1;
            end
        end
        for (int c = 0; c < 20000 && oc2 < 1000; c++) begin
            @(negedge clk);
            r2 = 1'($urandom_range(0, 1));
            if (wp2 < 1000 && $urandom_range(0, 3) != 0) wp2 = wp2 + 1;
        end
        r2 = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++; if (oc2 !== 1000) begin n_err++; $display("FAIL random_count got %0d exp 1000", oc2); end
        for (int i = 0; i < 1000; i++) begin
            n_vec++;
            if (out2[i] !== mem2[i]) begin
                n_err++; $display("FAIL random_word%0d got %h exp %h", i, out2[i], mem2[i]);
            end
        end
        n_vec++; if (fc2 !== 16'(nfr)) begin n_err++; $display("FAIL random_frame_cnt got %0d exp %0d", fc2, nfr); end
        n_vec++; if (ec2 !== 16'd0) begin n_err++; $display("FAIL random_err_cnt got %0d exp 0", ec2); end
        n_vec++; if (viol2 !== 0) begin n_err++; $display("FAIL random_rd_en_while_empty got %0d exp 0", viol2); end
        n_vec++; if (viol1 !== 0) begin n_err++; $display("FAIL lat1_rd_en_while_empty got %0d exp 0", viol1); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_tags();
        test_framing();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
